// File: rtl/kosei_audio_pkg.sv
// Shared audio constants, transmitter state encoding and width helper.
package kosei_audio_pkg;

    localparam int DEF_SAMPLE_WIDTH = 16;
    localparam int DEF_SLOT_BITS    = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tx_state_t;

    // Bits needed to hold values 0..v-1; never less than one bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/kosei_i2s_tx_if.sv
// Sample-pair stream into the I2S transmitter (valid/ready).
interface kosei_i2s_tx_if
    import kosei_audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH
);
    logic                    s_valid;
    logic                    s_ready;
    logic [SAMPLE_WIDTH-1:0] s_left;
    logic [SAMPLE_WIDTH-1:0] s_right;

    modport master (output s_valid, s_left, s_right, input s_ready);
    modport slave  (input s_valid, s_left, s_right, output s_ready);
endinterface

// File: rtl/kosei_i2s_tx_clkgen.sv
// BCLK divider and frame bit counter; parked at zero whenever run is low.
module kosei_i2s_tx_clkgen
    import kosei_audio_pkg::*;
#(
    parameter int SLOT_BITS = DEF_SLOT_BITS,
    parameter int BCLK_DIV  = 2,
    parameter int F_W       = clog2(2 * SLOT_BITS)
) (
    input  logic           clk_sys,
    input  logic           rst,
    input  logic           run,
    output logic           bclk,
    output logic           fall_pulse,
    output logic [F_W-1:0] f
);
    localparam int DW = clog2(BCLK_DIV);

    logic [DW-1:0] div_cnt;
    logic          div_term;

    assign div_term   = (div_cnt == DW'(BCLK_DIV - 1));
    // The next edge takes BCLK low: this is where f advances.
    assign fall_pulse = run && bclk && div_term;

    // Half-period divider, BCLK toggle, and f advance on each falling edge.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
            f       <= '0;
        end else if (!run) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
            f       <= '0;
        end else if (div_term) begin
            div_cnt <= '0;
            bclk    <= !bclk;
            if (bclk)
                f <= (f == F_W'(2 * SLOT_BITS - 1)) ? '0 : f + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/kosei_i2s_tx.sv
// Philips-format I2S master transmitter: one-entry holding register feeding
// an active stereo pair that is serialised MSB first, one BCLK late.
module kosei_i2s_tx
    import kosei_audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int SLOT_BITS    = DEF_SLOT_BITS,
    parameter int BCLK_DIV     = 2
) (
    input  logic           clk_sys,
    input  logic           rst,
    input  logic           enable,
    kosei_i2s_tx_if.slave  s,
    output logic           i2s_bclk,
    output logic           i2s_lrclk,
    output logic           i2s_data,
    output logic           busy,
    output logic           underrun,
    output logic [7:0]     underrun_count
);
    localparam int F_W = clog2(2 * SLOT_BITS);

    if (SAMPLE_WIDTH > SLOT_BITS) begin : g_bad_width
        $error("kosei_i2s_tx: SAMPLE_WIDTH must not exceed SLOT_BITS");
    end
    if (BCLK_DIV < 1) begin : g_bad_div
        $error("kosei_i2s_tx: BCLK_DIV must be at least 1");
    end

    tx_state_t               state;
    logic                    hold_valid;
    logic [SAMPLE_WIDTH-1:0] hold_l, hold_r;
    logic [SAMPLE_WIDTH-1:0] act_l, act_r;
    logic                    run, bclk, fall_pulse, load_edge, accept;
    logic [F_W-1:0]          f;

    int                      g_idx, k_idx;
    logic                    right_ch, bit_out;
    logic [SAMPLE_WIDTH-1:0] word, word_sh;

    assign run       = (state == RUN);
    assign s.s_ready = !hold_valid;
    assign accept    = s.s_valid && !hold_valid;
    // The f=0 -> f=1 edge is where the next pair is taken into service.
    assign load_edge = fall_pulse && (f == '0);

    kosei_i2s_tx_clkgen #(
        .SLOT_BITS (SLOT_BITS),
        .BCLK_DIV  (BCLK_DIV),
        .F_W       (F_W)
    ) u_clkgen (
        .clk_sys    (clk_sys),
        .rst        (rst),
        .run        (run),
        .bclk       (bclk),
        .fall_pulse (fall_pulse),
        .f          (f)
    );

    // Run/stop sequencing, holding register, active pair and underrun count.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            hold_valid     <= 1'b0;
            hold_l         <= '0;
            hold_r         <= '0;
            act_l          <= '0;
            act_r          <= '0;
            underrun_count <= '0;
        end else begin
            case (state)
                IDLE: if (enable) state <= RUN;
                RUN:  if (fall_pulse && f == F_W'(2 * SLOT_BITS - 1) && !enable)
                          state <= IDLE;
                default: state <= IDLE;
            endcase

            if (load_edge) begin
                act_l <= hold_valid ? hold_l : '0;
                act_r <= hold_valid ? hold_r : '0;
                if (!hold_valid && underrun_count != 8'hFF)
                    underrun_count <= underrun_count + 8'd1;
            end

            // s_ready is low while full, so an accept never meets a load of a full hold.
            if (accept) begin
                hold_l     <= s.s_left;
                hold_r     <= s.s_right;
                hold_valid <= 1'b1;
            end else if (load_edge) begin
                hold_valid <= 1'b0;
            end
        end
    end

    // Bit selection: the slot bit at f belongs to position f-1 (one-bit delay).
    always_comb begin
        g_idx    = (f == '0) ? (2 * SLOT_BITS - 1) : (int'(f) - 1);
        right_ch = (g_idx >= SLOT_BITS);
        k_idx    = right_ch ? (g_idx - SLOT_BITS) : g_idx;
        word     = right_ch ? act_r : act_l;
        word_sh  = word << k_idx;
        bit_out  = (k_idx < SAMPLE_WIDTH) ? word_sh[SAMPLE_WIDTH-1] : 1'b0;
    end

    assign i2s_bclk  = bclk;
    assign i2s_lrclk = run ? (f >= F_W'(SLOT_BITS)) : 1'b1;
    assign i2s_data  = run && bit_out;
    assign busy      = run;
    assign underrun  = load_edge && !hold_valid;

endmodule

// File: tb/tb_kosei_i2s_tx.sv
// Randomised bench for kosei_i2s_tx with a time-indexed behavioural model.
module tb_kosei_i2s_tx;
    localparam int W  = 16;
    localparam int S  = 32;
    localparam int D  = 2;
    localparam int BP = 2 * D;        // clk_sys cycles per bit
    localparam int FR = 2 * S * BP;   // clk_sys cycles per frame

    logic       clk_sys = 1'b0;
    logic       rst;
    logic       enable;
    logic       i2s_bclk, i2s_lrclk, i2s_data, busy, underrun;
    logic [7:0] underrun_count;

    kosei_i2s_tx_if #(.SAMPLE_WIDTH(W)) sif ();

    kosei_i2s_tx #(.SAMPLE_WIDTH(W), .SLOT_BITS(S), .BCLK_DIV(D)) dut (
        .clk_sys        (clk_sys),
        .rst            (rst),
        .enable         (enable),
        .s              (sif),
        .i2s_bclk       (i2s_bclk),
        .i2s_lrclk      (i2s_lrclk),
        .i2s_data       (i2s_data),
        .busy           (busy),
        .underrun       (underrun),
        .underrun_count (underrun_count)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // t counts clk_sys cycles since RUN entry; everything else follows from it.
    bit          m_run;
    int          t;
    bit          m_hv;
    logic [W-1:0] m_hl, m_hr, m_al, m_ar;
    int          m_cnt;

    always @(posedge clk_sys or posedge rst) begin
        bit acc;
        if (rst) begin
            m_run = 0; t = 0; m_hv = 0;
            m_hl = '0; m_hr = '0; m_al = '0; m_ar = '0; m_cnt = 0;
        end else begin
            acc = sif.s_valid && !m_hv;
            if (m_run) begin
                if (t % FR == BP - 1) begin
                    if (m_hv) begin
                        m_al = m_hl; m_ar = m_hr; m_hv = 0;
                    end else begin
                        m_al = '0; m_ar = '0;
                        if (m_cnt < 255) m_cnt++;
                    end
                end
                if (t % FR == FR - 1 && !enable) m_run = 0;
                else t++;
            end else if (enable) begin
                m_run = 1; t = 0;
            end
            if (acc) begin
                m_hl = sif.s_left; m_hr = sif.s_right; m_hv = 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int ur_seen  = 0;
    int busy_cyc = 0;
    int          c_ph, c_f, c_g, c_k;
    logic        e_bclk, e_lr, e_data, e_ur;
    logic [W-1:0] c_w, c_tmp;

    always @(negedge clk_sys) begin
        if (!rst) begin
            if (m_run) begin
                c_ph   = t % FR;
                c_f    = c_ph / BP;
                e_bclk = (c_ph % BP) >= D;
                e_lr   = c_f >= S;
                c_g    = (c_f + 2 * S - 1) % (2 * S);
                c_k    = c_g % S;
                c_w    = (c_g >= S) ? m_ar : m_al;
                c_tmp  = c_w >> (W - 1 - c_k);
                e_data = (c_k < W) ? c_tmp[0] : 1'b0;
                e_ur   = (c_ph == BP - 1) && !m_hv;
            end else begin
                e_bclk = 0; e_lr = 1; e_data = 0; e_ur = 0;
            end
            check("cycle", {i2s_bclk, i2s_lrclk, i2s_data, busy, underrun, sif.s_ready, underrun_count},
                  {e_bclk, e_lr, e_data, m_run, e_ur, !m_hv, 8'(m_cnt)});
            if (underrun) ur_seen++;
            if (busy) busy_cyc++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_pair(input logic [W-1:0] l, input logic [W-1:0] r);
        int n; logic rdy;
        sif.s_left = l; sif.s_right = r; sif.s_valid = 1'b1;
        n = 0; rdy = 1'b0;
        while (!rdy && n < 2000) begin
            @(negedge clk_sys);
            rdy = sif.s_ready;
            n++;
        end
        check("send_ready", 64'(rdy), 64'd1);
        @(posedge clk_sys); #1;
        sif.s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (busy && n < 3 * FR);
        check("idle_reached", 64'(busy), 64'd0);
        @(posedge clk_sys); #1;
    endtask

    task automatic wait_f(input int target);
        int n; bit hit;
        n = 0; hit = 0;
        while (!hit && n < 3 * FR) begin
            @(posedge clk_sys); #1;
            hit = m_run && ((t % FR) / BP == target);
            n++;
        end
        check("wait_f", 64'(hit), 64'd1);
    endtask

    task automatic capture_frame(output logic [63:0] db, output logic [63:0] lb);
        int n; logic prev;
        n = 0; prev = 1'b0; db = '0; lb = '0;
        for (int c = 0; c < 2 * FR && n < 64; c++) begin
            @(negedge clk_sys);
            if (i2s_bclk && !prev) begin
                db[n] = i2s_data;
                lb[n] = i2s_lrclk;
                n++;
            end
            prev = i2s_bclk;
        end
        check("frame_bits", 64'(n), 64'd64);
    endtask

    // ---------------- test sequence ----------------
    logic [63:0] db, lb;
    logic [15:0] lw, rw;
    int ur0, b0;

    initial begin
        rst = 1'b1; enable = 1'b0;
        sif.s_valid = 1'b0; sif.s_left = '0; sif.s_right = '0;
        repeat (3) @(negedge clk_sys);
        check("reset", {i2s_bclk, i2s_lrclk, i2s_data, sif.s_ready, busy, underrun, underrun_count},
              {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0});
        @(posedge clk_sys); #1 rst = 1'b0;

        // Single frame with a prefilled pair; enable for one cycle only.
        send_pair(16'hA5C3, 16'h8001);
        enable = 1'b1;
        @(posedge clk_sys); #1 enable = 1'b0;
        capture_frame(db, lb);
        for (int i = 0; i < 16; i++) begin
            lw[15 - i] = db[1 + i];
            rw[15 - i] = db[33 + i];
        end
        check("left_word", 64'(lw), 64'h A5C3);
        check("right_word", 64'(rw), 64'h 8001);
        check("lrclk_pattern", lb, 64'hFFFF_FFFF_0000_0000);
        check("pad_zero", db & ~64'h0001_FFFE_0001_FFFE, 64'd0);
        wait_idle();

        // Backpressure: 8 pairs with random gaps, no underrun expected.
        ur0 = ur_seen;
        send_pair(16'h1111, 16'hEEEE);
        enable = 1'b1;
        for (int i = 1; i < 8; i++) begin
            repeat ($urandom_range(0, 40)) @(posedge clk_sys);
            #1 send_pair(16'($urandom), 16'($urandom));
        end
        wait_f(5);
        enable = 1'b0;
        wait_idle();
        check("bp_no_underrun", 64'(ur_seen - ur0), 64'd0);

        // Graceful stop at f = 10: the frame still runs all 256 cycles.
        b0 = busy_cyc;
        enable = 1'b1;
        wait_f(10);
        enable = 1'b0;
        wait_idle();
        repeat (5) @(posedge clk_sys);
        check("stop_len", 64'(busy_cyc - b0), 64'(FR));
        @(negedge clk_sys);
        check("stop_idle", {i2s_bclk, i2s_lrclk, busy}, {1'b0, 1'b1, 1'b0});

        // Reset mid-frame with the hold full; hold contents must be lost.
        @(posedge clk_sys); #1;
        send_pair(16'h2468, 16'h1357);
        enable = 1'b1;
        wait_f(5);
        send_pair(16'h7F00, 16'h00FF);
        wait_f(20);
        rst = 1'b1; enable = 1'b0;
        #1 check("rst_mid", {i2s_bclk, i2s_lrclk, i2s_data, sif.s_ready, busy, underrun_count},
                 {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0});
        @(posedge clk_sys); #1 rst = 1'b0;
        ur0 = ur_seen;
        enable = 1'b1;
        @(posedge clk_sys); #1 enable = 1'b0;
        wait_idle();
        check("rst_underrun_pulse", 64'(ur_seen - ur0), 64'd1);
        check("rst_underrun_cnt", 64'(underrun_count), 64'd1);

        // Random enable / valid / data traffic.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk_sys); #1;
            if ($urandom_range(0, 99) < 2) enable = !enable;
            sif.s_valid = ($urandom_range(0, 3) == 0);
            sif.s_left  = 16'($urandom);
            sif.s_right = 16'($urandom);
        end
        sif.s_valid = 1'b0; enable = 1'b0;
        wait_idle();

        // Underrun saturation over 258 empty frames.
        rst = 1'b1;
        @(posedge clk_sys); #1 rst = 1'b0;
        ur0 = ur_seen;
        enable = 1'b1;
        repeat (258 * FR - 20) @(posedge clk_sys);
        #1 enable = 1'b0;
        wait_idle();
        check("sat_pulses", 64'(ur_seen - ur0), 64'd258);
        check("sat_count", 64'(underrun_count), 64'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/kosei_i2s_tx.md
# kosei_i2s_tx

I2S master transmitter for the Kosei audio chip: it accepts stereo PCM sample pairs over a valid/ready handshake and serialises them onto a standard Philips-format I2S link. It generates its own BCLK and LRCLK from the system clock. It is the transmit counterpart of the chip's I2S receive path and drives external codecs or loopback test of the receiver.

## Interface
- SAMPLE_WIDTH, 16, PCM bits per channel; must be ≤ SLOT_BITS.
- SLOT_BITS, 32, BCLK periods per channel slot; a frame is 2×SLOT_BITS.
- BCLK_DIV, 2, clk_sys cycles per BCLK half-period; must be ≥ 1.
- clk_sys  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  run request.
- s_valid  in  1  sample pair offered.
- s_ready  out  1  holding register empty; equals !hold_valid.
- s_left  in  SAMPLE_WIDTH  left sample, two's complement.
- s_right  in  SAMPLE_WIDTH  right sample, two's complement.
- i2s_bclk  out  1  bit clock.
- i2s_lrclk  out  1  word select: 0 = left, 1 = right.
- i2s_data  out  1  serial data, MSB first.
- busy  out  1  state is RUN.
- underrun  out  1  one-cycle pulse when a frame starts without a sample.
- underrun_count  out  8  saturating underrun counter.

## Operation
- **Reset values.** bclk 0, lrclk 1, data 0, busy 0, underrun 0, underrun_count 0, hold empty (s_ready 1), active pair 0, state IDLE.
- **States.**
  - IDLE→RUN when enable = 1.
  - RUN→IDLE only at frame wrap (f = 2S−1 falling edge) with enable = 0. An enable drop mid-frame completes the frame.
- **Holding register.**
  - One entry. Transfer occurs when s_valid && s_ready, in IDLE or RUN. Prefill is allowed.
- **Frame counter f.** Range 0..2S−1 (S = SLOT_BITS, W = SAMPLE_WIDTH). Advances on each BCLK falling edge; on RUN entry f = 0.
- **Outputs at f.**
  - i2s_lrclk = (f ≥ S).
  - g = (f + 2S − 1) mod 2S. Channel is right if g ≥ S, else left. k = g mod S.
  - i2s_data = active_channel[W−1−k] if k < W, else 0. This gives the one-bit I2S delay after each LRCLK edge.
- **Load at f→1 transition.**
  - Hold full: active pair ← hold, hold empties. The data driven at f = 1 is the new left MSB.
  - Hold empty: active pair ← 0 (mute), underrun pulses, underrun_count += 1, saturating at 255.
  - The bit at f = 0 (right slot last bit) still uses the previous active pair.
- **IDLE outputs.** bclk 0, lrclk 1, data 0. The active pair is kept.
- **Reset mid-operation.** Immediate return to reset values. The hold contents are discarded.

## Timing
- RUN entry occurs one clk_sys cycle after enable is sampled high. Outputs for f = 0 (lrclk 0, data per rule) are valid in the first RUN cycle.
- BCLK toggles every BCLK_DIV cycles. It is high for cycles [BCLK_DIV, 2·BCLK_DIV) of each bit period. Falling edge with f advance every 2·BCLK_DIV cycles.
- Frame length is 2S·2·BCLK_DIV clk_sys cycles (256 with defaults).
- lrclk and data change only coincident with a BCLK falling edge, so they are stable across each rising edge.
- s_ready is combinational from hold_valid:
  - It rises the cycle after the f→1 load.
  - An accept in that cycle is legal.
  - Load and accept never coincide.
- underrun is high for exactly the clk_sys cycle of the f→1 transition.
- On IDLE return, busy falls in the cycle after the final falling edge. BCLK stays low.

## Structure
- Shared kosei_audio_pkg holds:
  - Default constants SAMPLE_WIDTH = 16, SLOT_BITS = 32.
  - The state enum {IDLE, RUN}.
  - The clog2 helper for counter widths (f needs clog2(2S) bits; the divider needs clog2(BCLK_DIV) bits).
- Sub-module kosei_i2s_tx_clkgen contains:
  - The BCLK divider and frame counter f.
  - Outputs: bclk, fall_pulse, f.
- The top level contains the FSM, holding register, active pair, bit select and underrun logic.
- Parameter legality checks are elaboration-time assertions.

## Test plan
- **Reset.** Assert rst mid-run → bclk 0, lrclk 1, data 0, s_ready 1, busy 0, underrun_count 0 in the same cycle.
- **Single frame.** Prefill L = 16'hA5C3, R = 16'h8001, enable with BCLK_DIV = 2:
  - Bit period is 4 cycles.
  - lrclk 0 for f 0..31; data f1..16 = A5C3 MSB-first; f17..32 = 0.
  - lrclk 1 for f 32..63; data f33..48 = 8001; rest 0.
- **Underrun.** Enable with no sample → underrun pulses once per frame and all-zero data. After 300 frames underrun_count = 255.
- **Backpressure.** Hold s_valid with 8 distinct pairs and random gaps → s_ready low while full. Each pair is transmitted exactly once, in order, with no underrun.
- **Graceful stop.** Drop enable at f = 10 → the frame completes to f = 63, then IDLE. busy 0, bclk stays 0, lrclk 1.
- **Reset mid-frame.** Assert rst at f = 20 with hold full, release, re-enable → the hold is discarded. The new frame starts at f = 0 and underruns unless refilled.
